instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction-register controller. It owns the program counter and issues reads to instruction memory. It captures each returned instruction word and presents it as a stable `PC`/`ir` pair. It holds that pair until the controller signals that the instruction has finished, then advances; after the last instruction it halts.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_latency.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default IM base address and the supported IM read-latency range.
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  localparam int IM_BASE_DEFAULT = 'h80;
  localparam int IM_LATENCY_MIN  = 1;
  localparam int IM_LATENCY_MAX  = 7;
  localparam int LAT_CNT_W       = 3;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is the master, memory the slave.
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int DataSize   = 32,
  parameter int IMAddrSize = 10
);

  logic                  im_enable;
  logic                  im_read;
  logic [IMAddrSize-1:0] im_address;
  logic [DataSize-1:0]   im_rdata;

  modport master (
    output im_enable,
    output im_read,
    output im_address,
    input  im_rdata
  );

  modport slave (
    input  im_enable,
    input  im_read,
    input  im_address,
    output im_rdata
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_latency.sv
// im_latency_counter: 3-bit down-counter timing the IM read latency;
// loaded on the request cycle, expire is high while the count sits at zero.
`default_nettype none

module im_latency_counter
  import fetch_pkg::*;
#(
  parameter int IM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam logic [LAT_CNT_W-1:0] LoadVal = LAT_CNT_W'(IM_LATENCY - 1);

  logic [LAT_CNT_W-1:0] count_q;
  logic [LAT_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from IM and holds PC/ir until ins_done.
// Optional FETCH_ZERO_HALT_EN: a captured all-zero word halts instead of presenting.
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int MemSize    = 10,
  parameter int DataSize   = 32,
  parameter int IMAddrSize = 10,
  parameter int IM_BASE    = IM_BASE_DEFAULT,
  parameter int IM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         total_ir,
  input  logic                ins_done,
  instr_fetch_unit_if.master  im,
  output logic [MemSize-1:0]  PC,
  output logic [DataSize-1:0] ir,
  output logic                ir_valid,
  output logic                halt
);

`ifdef FETCH_ZERO_HALT_EN
  localparam bit ZeroHalt = 1'b1;
`else
  localparam bit ZeroHalt = 1'b0;
`endif

  localparam int CmpW = (MemSize > 16) ? MemSize : 16;

  fetch_state_e        state_q;
  logic [MemSize-1:0]  pc_q;
  logic [DataSize-1:0] ir_q;
  logic                valid_q;
  logic                halt_q;
  logic                rd_q;
  logic                lat_expire;
  logic                pc_last;

  im_latency_counter #(
    .IM_LATENCY (IM_LATENCY)
  ) u_lat (
    .clock  (clock),
    .reset  (reset),
    .load   (state_q == ST_REQ),
    .expire (lat_expire)
  );

  // PC saturates: the all-ones PC is treated as the last instruction.
  assign pc_last = (CmpW'(pc_q) >= CmpW'(total_ir)) || (&pc_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (total_ir == 16'd0) begin
              halt_q  <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              pc_q    <= MemSize'(1);
              rd_q    <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_expire) begin
            ir_q <= im.im_rdata;
            if (ZeroHalt && (im.im_rdata == '0)) begin
              halt_q  <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ins_done) begin
            valid_q <= 1'b0;
            if (pc_last) begin
              halt_q  <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              pc_q    <= pc_q + 1'b1;
              rd_q    <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign im.im_enable  = rd_q;
  assign im.im_read    = rd_q;
  assign im.im_address = (pc_q == '0) ? '0
                       : IMAddrSize'(IM_BASE) + IMAddrSize'(pc_q) - IMAddrSize'(1);

  assign PC       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = valid_q;
  assign halt     = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at IM latency 1, one at 3.
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] WORD_A = 32'hA0A0_0001;
  localparam logic [31:0] WORD_B = 32'hB0B0_0002;
  localparam logic [31:0] WORD_C = 32'hC0C0_0003;

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] ir;
    logic [9:0]  addr;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] total_ir;
  logic        start_a, start_b, done_a, done_b;
  logic [9:0]  pc_a, pc_b;
  logic [31:0] ir_a, ir_b;
  logic        valid_a, valid_b, halt_a, halt_b;

  logic [31:0] mem [0:1023];
  logic [31:0] pa1, pb1, pb2, pb3;
  int          reads_a, reads_b;
  logic [9:0]  last_addr_a, last_addr_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   checks, errors;

  instr_fetch_unit_if #(.DataSize(32), .IMAddrSize(10)) ifa ();
  instr_fetch_unit_if #(.DataSize(32), .IMAddrSize(10)) ifb ();

  instr_fetch_unit #(.IM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .total_ir(total_ir),
    .ins_done(done_a), .im(ifa), .PC(pc_a), .ir(ir_a), .ir_valid(valid_a), .halt(halt_a)
  );

  instr_fetch_unit #(.IM_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .total_ir(total_ir),
    .ins_done(done_b), .im(ifb), .PC(pc_b), .ir(ir_b), .ir_valid(valid_b), .halt(halt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // IM models: data appears IM_LATENCY cycles after the read strobe
  always @(posedge clock) begin
    pa1 <= ifa.im_read ? mem[ifa.im_address] : 32'h0;
    pb1 <= ifb.im_read ? mem[ifb.im_address] : 32'h0;
    pb2 <= pb1;
    pb3 <= pb2;
    if (ifa.im_read && ifa.im_enable) begin
      reads_a     <= reads_a + 1;
      last_addr_a <= ifa.im_address;
    end
    if (ifb.im_read && ifb.im_enable) begin
      reads_b     <= reads_b + 1;
      last_addr_b <= ifb.im_address;
    end
  end
  assign ifa.im_rdata = pa1;
  assign ifb.im_rdata = pb3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid_a(output int n);
    n = 0;
    while (valid_a !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout_a", n < 20, 1);
  endtask

  task automatic wait_valid_b(output int n);
    n = 0;
    while (valid_b !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout_b", n < 20, 1);
  endtask

  task automatic pop_a();
    exp_t e;
    check("sb_a_nonempty", sb_a.size() != 0, 1);
    e = sb_a.pop_front();
    check("a_valid", valid_a, 1);
    check("a_pc", pc_a, e.pc);
    check("a_ir", ir_a, e.ir);
    check("a_addr", last_addr_a, e.addr);
  endtask

  task automatic pop_b();
    exp_t e;
    check("sb_b_nonempty", sb_b.size() != 0, 1);
    e = sb_b.pop_front();
    check("b_valid", valid_b, 1);
    check("b_pc", pc_b, e.pc);
    check("b_ir", ir_b, e.ir);
    check("b_addr", last_addr_b, e.addr);
  endtask

  initial begin
    int n;
    int r0;
    checks = 0; errors = 0;
    reads_a = 0; reads_b = 0;
    last_addr_a = '0; last_addr_b = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem['h80] = WORD_A;
    mem['h81] = WORD_B;
    mem['h82] = WORD_C;
    reset = 1'b1; total_ir = 16'd0;
    start_a = 1'b0; start_b = 1'b0; done_a = 1'b0; done_b = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_pc", pc_a, 0);
    check("rst_ir", ir_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_halt", halt_a, 0);
    check("rst_strobe", {ifa.im_enable, ifa.im_read}, 0);
    check("rst_addr", ifa.im_address, 0);
    check("rst_b_pc", pc_b, 0);
    reset = 1'b0;
    tick();

    // Three-instruction program, latency 1
    total_ir = 16'd3;
    sb_a.push_back('{pc: 10'd1, ir: WORD_A, addr: 10'h080});
    sb_a.push_back('{pc: 10'd2, ir: WORD_B, addr: 10'h081});
    sb_a.push_back('{pc: 10'd3, ir: WORD_C, addr: 10'h082});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("req_strobe", {ifa.im_enable, ifa.im_read}, 2'b11);
    check("req_addr", ifa.im_address, 10'h080);
    done_a = 1'b1;                       // spurious ins_done through REQ and WAIT
    tick();
    check("wait_strobe", ifa.im_read, 0);
    check("wait_valid", valid_a, 0);
    tick();
    done_a = 1'b0;
    pop_a();                             // start + 3 edges = 2 + latency
    start_a = 1'b1;                      // start in HOLD is ignored
    tick();
    start_a = 1'b0;
    check("hold_start_pc", pc_a, 1);
    check("hold_start_valid", valid_a, 1);
    check("hold_start_reads", reads_a, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check("done_drop", valid_a, 0);
      wait_valid_a(n);
      check("turnaround_a", n + 1, 3);
      pop_a();
      tick();
      tick();
    end
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("halt_rise", halt_a, 1);
    check("halt_valid", valid_a, 0);
    repeat (5) tick();
    check("halt_sticky", halt_a, 1);
    check("halt_reads", reads_a, 3);
    check("halt_pc", pc_a, 3);

    // total_ir == 0 halts immediately
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_clears_halt", halt_a, 0);
    total_ir = 16'd0;
    r0 = reads_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("zero_prog_halt", halt_a, 1);
    check("zero_prog_pc", pc_a, 0);
    check("zero_prog_read", ifa.im_read, 0);
    tick();
    check("zero_prog_reads", reads_a, r0);

    // Latency 3 on instance B; ir held while ins_done stays low
    total_ir = 16'd3;
    sb_b.push_back('{pc: 10'd1, ir: WORD_A, addr: 10'h080});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_valid_b(n);
    check("lat3_rise", n + 1, 5);
    pop_b();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("lat3_hold_ir", ir_b, WORD_A);
    end
    check("lat3_hold_pc", pc_b, 1);

    // Reset while B is in WAIT, then refetch from the base address
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check("b_req_read", ifb.im_read, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrst_pc", pc_b, 0);
    check("wrst_ir", ir_b, 0);
    check("wrst_valid", valid_b, 0);
    check("wrst_halt", halt_b, 0);
    check("wrst_strobe", {ifb.im_enable, ifb.im_read}, 0);
    check("wrst_addr", ifb.im_address, 0);
    r0 = reads_b;
    sb_b.push_back('{pc: 10'd1, ir: WORD_A, addr: 10'h080});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("refetch_addr", ifb.im_address, 10'h080);
    check("refetch_read", ifb.im_read, 1);
    wait_valid_b(n);
    check("refetch_lat", n + 1, 5);
    pop_b();
    check("refetch_reads", reads_b, r0 + 1);

    // All-zero second word
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem['h81] = 32'h0;
    total_ir = 16'd3;
    sb_a.push_back('{pc: 10'd1, ir: WORD_A, addr: 10'h080});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid_a(n);
    check("zw_lat", n + 1, 3);
    pop_a();
    tick();
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check("zw_wait_valid", valid_a, 0);
    tick();
`ifdef FETCH_ZERO_HALT_EN
    check("zw_halt", halt_a, 1);
    check("zw_valid", valid_a, 0);
    check("zw_pc", pc_a, 2);
    check("zw_ir", ir_a, 0);
    repeat (3) tick();
    check("zw_valid_later", valid_a, 0);
`else
    sb_a.push_back('{pc: 10'd2, ir: 32'h0, addr: 10'h081});
    pop_a();
    check("zw_no_halt", halt_a, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
